// File: rtl/outport_uart_tx.sv
// outport_uart_tx
// Queues each datapath output-port write and replays it on a UART line as
// four 8N1 bytes, least-significant byte first.
//
// Ports
//   Clock      system clock, rising edge
//   Clear      asynchronous active-low reset
//   OutData    32-bit output-port word, captured on a Strobe rising edge
//   Strobe     output-port write strobe (level); rising edge = one push
//   Tx         UART serial line, idles high, registered
//   Busy       frame in progress or words queued
//   Overflow   sticky: a word was dropped because the FIFO was full
//   FifoCount  queued words, not counting the word being sent
//
// state | meaning
// IDLE  | line high, waiting for a queued word
// START | start bit (low) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); then next byte, next word, or IDLE
module outport_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          Clock,
   input  logic                          Clear,
   input  logic [31:0]                   OutData,
   input  logic                          Strobe,
   output logic                          Tx,
   output logic                          Busy,
   output logic                          Overflow,
   output logic [$clog2(FIFO_DEPTH):0]   FifoCount
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   state_t         state_q, state_d;
   logic [BW-1:0]  baud_q, baud_d;
   logic [2:0]     bit_q, bit_d;
   logic [1:0]     byte_q, byte_d;
   logic [7:0]     shift_q, shift_d;
   logic [31:0]    hold_q, hold_d;
   logic           tx_q, tx_d;
   logic           busy_q, busy_d;
   logic           overflow_q, overflow_d;
   logic           strobe_q, strobe_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [31:0]    mem_q [FIFO_DEPTH];
   logic [31:0]    mem_d [FIFO_DEPTH];

   logic           push_req;
   logic           push_ok;
   logic           pop;
   logic           full;
   logic [1:0]     byte_nxt;

   assign push_req = Strobe & ~strobe_q;
   assign full     = (count_q == DEPTH_C);
   assign byte_nxt = byte_q + 2'd1;

   // Transmit FSM; pop is raised wherever a new word enters the holding register.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      hold_d  = hold_q;
      pop     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               hold_d  = mem_q[rd_ptr_q];
               shift_d = mem_q[rd_ptr_q][7:0];
               byte_d  = 2'd0;
               baud_d  = BAUD_LAST;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (baud_q == '0) begin
               baud_d  = BAUD_LAST;
               bit_d   = 3'd0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         ST_DATA: begin
            if (baud_q == '0) begin
               baud_d  = BAUD_LAST;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         ST_STOP: begin
            if (baud_q == '0) begin
               baud_d = BAUD_LAST;
               if (byte_q != 2'd3) begin
                  byte_d  = byte_nxt;
                  shift_d = hold_q[{byte_nxt, 3'b000} +: 8];
                  state_d = ST_START;
               end else if (count_q != '0) begin
                  // next word follows the stop bit with no idle gap
                  pop     = 1'b1;
                  hold_d  = mem_q[rd_ptr_q];
                  shift_d = mem_q[rd_ptr_q][7:0];
                  byte_d  = 2'd0;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FIFO bookkeeping. A pop frees a slot in the same cycle, so a push into a
   // full FIFO is still accepted when it coincides with a pop.
   always_comb begin
      strobe_d   = Strobe;
      push_ok    = push_req & (~full | pop);
      overflow_d = overflow_q | (push_req & full & ~pop);
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = OutData;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop);
   end

   // Tx and Busy come from next-state values so both are clean flop outputs.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != ST_IDLE) | (count_d != '0);
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         byte_q     <= '0;
         shift_q    <= '0;
         hold_q     <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
         strobe_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         byte_q     <= byte_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
         strobe_q   <= strobe_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         mem_q      <= mem_d;
      end
   end

   assign Tx        = tx_q;
   assign Busy      = busy_q;
   assign Overflow  = overflow_q;
   assign FifoCount = count_q;

endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed bench for outport_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_outport_uart_tx;

   localparam int CPB = 4;

   logic        Clock;
   logic        Clear;
   logic [31:0] OutData;
   logic        Strobe;
   logic        Tx;
   logic        Busy;
   logic        Overflow;
   logic [2:0]  FifoCount;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   outport_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .Clock     (Clock),
      .Clear     (Clear),
      .OutData   (OutData),
      .Strobe    (Strobe),
      .Tx        (Tx),
      .Busy      (Busy),
      .Overflow  (Overflow),
      .FifoCount (FifoCount)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   // Receives one 8N1 byte: waits (bounded) for a start bit, samples mid-bit.
   // waited = number of negedges spent before the start bit was seen.
   task automatic recv_byte(output logic [7:0] b, output int waited, output bit ok);
      int w;
      w  = 0;
      ok = 1'b1;
      b  = 8'h00;
      while (Tx !== 1'b0 && w < 2000) begin
         @(negedge Clock);
         w++;
      end
      waited = w;
      if (Tx !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      repeat (CPB / 2) @(negedge Clock);
      if (Tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge Clock);
         b[i] = Tx;
      end
      repeat (CPB) @(negedge Clock);
      if (Tx !== 1'b1) ok = 1'b0;
   endtask

   task automatic test_reset;
      int n;
      Clear   = 1'b0;
      Strobe  = 1'b0;
      OutData = 32'h0;
      repeat (3) @(negedge Clock);
      checks++; if (Tx !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b want 1", Tx); end
      checks++; if (Busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", Overflow); end
      checks++; if (FifoCount !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", FifoCount); end
      // Strobe already high at reset release is a rising edge
      Strobe  = 1'b1;
      OutData = 32'h0000_00AA;
      @(negedge Clock);
      Clear = 1'b1;
      @(negedge Clock);
      checks++; if (FifoCount !== 3'd1) begin errors++; $display("FAIL reset_strobe_high_push: count got %0d want 1", FifoCount); end
      Strobe = 1'b0;
      n = 0;
      while (Busy === 1'b1 && n < 400) begin @(negedge Clock); n++; end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_strobe_drain: busy got %b want 0", Busy); end
      Clear = 1'b0;
      @(negedge Clock);
      Clear = 1'b1;
      @(negedge Clock);
   endtask

   task automatic test_single_word;
      logic [7:0] b;
      int         w, t0;
      bit         ok;
      logic [7:0] exp [4];
      exp = '{8'h41, 8'h00, 8'h00, 8'h00};
      @(negedge Clock);
      OutData = 32'h0000_0041;
      Strobe  = 1'b1;
      @(negedge Clock);
      checks++; if (FifoCount !== 3'd1) begin errors++; $display("FAIL single_count_push: got %0d want 1", FifoCount); end
      checks++; if (Tx !== 1'b1)        begin errors++; $display("FAIL single_tx_push: got %b want 1", Tx); end
      checks++; if (Busy !== 1'b1)      begin errors++; $display("FAIL single_busy: got %b want 1", Busy); end
      Strobe  = 1'b0;
      OutData = 32'hFFFF_FFFF;
      @(negedge Clock);
      t0 = cyc;
      checks++; if (Tx !== 1'b0)        begin errors++; $display("FAIL single_tx_fall: got %b want 0", Tx); end
      checks++; if (FifoCount !== 3'd0) begin errors++; $display("FAIL single_count_pop: got %0d want 0", FifoCount); end
      for (int j = 0; j < 4; j++) begin
         recv_byte(b, w, ok);
         checks++;
         if (!ok || b !== exp[j]) begin
            errors++; $display("FAIL single_byte%0d: got %h frame_ok=%0d want %h", j, b, ok, exp[j]);
         end
      end
      while (Busy === 1'b1 && cyc - t0 < 400) @(negedge Clock);
      checks++; if (cyc - t0 != 160) begin errors++; $display("FAIL single_busy_len: got %0d cycles want 160", cyc - t0); end
      checks++; if (FifoCount !== 3'd0) begin errors++; $display("FAIL single_count_end: got %0d want 0", FifoCount); end
   endtask

   task automatic test_long_strobe;
      logic [7:0] b;
      int         w, n, bad;
      bit         ok;
      fork
         begin
            @(negedge Clock);
            OutData = 32'hA5A5_A5A5;
            Strobe  = 1'b1;
            @(negedge Clock);
            bad = 0;
            for (int i = 1; i < 20; i++) begin
               if (i == 8) OutData = 32'h1234_5678;
               @(negedge Clock);
               if (FifoCount !== 3'd0) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL long_count_held: %0d cycles nonzero want 0", bad); end
            Strobe = 1'b0;
         end
         begin
            for (int j = 0; j < 4; j++) begin
               recv_byte(b, w, ok);
               checks++;
               if (!ok || b !== 8'hA5) begin
                  errors++; $display("FAIL long_byte%0d: got %h frame_ok=%0d want a5", j, b, ok);
               end
            end
         end
      join
      n = 0;
      while (Busy === 1'b1 && n < 100) begin @(negedge Clock); n++; end
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge Clock);
         if (Tx !== 1'b1 || Busy !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL long_extra_word: %0d active cycles after 4 bytes want 0", bad); end
   endtask

   task automatic test_back_to_back;
      logic [7:0]  b;
      int          w;
      bit          ok;
      logic [31:0] words [3];
      words = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               @(negedge Clock);
               OutData = words[k];
               Strobe  = 1'b1;
               @(negedge Clock);
               Strobe  = 1'b0;
            end
         end
         begin
            for (int j = 0; j < 12; j++) begin
               recv_byte(b, w, ok);
               checks++;
               if (!ok || b !== words[j/4][8*(j%4) +: 8]) begin
                  errors++; $display("FAIL b2b_byte%0d: got %h frame_ok=%0d want %h", j, b, ok, words[j/4][8*(j%4) +: 8]);
               end
               if (j > 0) begin
                  checks++;
                  if (w != 2) begin errors++; $display("FAIL b2b_gap%0d: waited %0d negedges want 2", j, w); end
               end
            end
         end
      join
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", Overflow); end
   endtask

   task automatic test_overflow;
      logic [7:0]  b;
      int          w, n;
      bit          ok;
      logic [31:0] words [5];
      words = '{32'h1234_5678, 32'h1, 32'h2, 32'h3, 32'h4};
      fork
         begin
            @(negedge Clock);
            OutData = words[0];
            Strobe  = 1'b1;
            @(negedge Clock);
            Strobe  = 1'b0;
            repeat (4) @(negedge Clock);
            for (int v = 1; v <= 5; v++) begin
               OutData = 32'(v);
               Strobe  = 1'b1;
               @(negedge Clock);
               if (v == 4) begin
                  checks++;
                  if (FifoCount !== 3'd4 || Overflow !== 1'b0) begin
                     errors++; $display("FAIL ovf_fill: count %0d ovf %b want 4 0", FifoCount, Overflow);
                  end
               end
               Strobe = 1'b0;
               @(negedge Clock);
            end
            checks++; if (FifoCount !== 3'd4) begin errors++; $display("FAIL ovf_count_sat: got %0d want 4", FifoCount); end
            checks++; if (Overflow !== 1'b1)  begin errors++; $display("FAIL ovf_flag: got %b want 1", Overflow); end
         end
         begin
            for (int j = 0; j < 20; j++) begin
               recv_byte(b, w, ok);
               checks++;
               if (!ok || b !== words[j/4][8*(j%4) +: 8]) begin
                  errors++; $display("FAIL ovf_byte%0d: got %h frame_ok=%0d want %h", j, b, ok, words[j/4][8*(j%4) +: 8]);
               end
            end
         end
      join
      n = 0;
      while (Busy === 1'b1 && n < 50) begin @(negedge Clock); n++; end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ovf_dropped_sent: busy got %b want 0", Busy); end
      repeat (20) @(negedge Clock);
      checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", Overflow); end
   endtask

   task automatic test_collision;
      logic [7:0]  b;
      int          w, n, t0;
      bit          ok;
      logic [31:0] words [6];
      words = '{32'hA3A2_A1A0, 32'hB1B1_B1B1, 32'hB2B2_B2B2, 32'hB3B3_B3B3, 32'hB4B4_B4B4, 32'hC3C2_C1C0};
      @(negedge Clock);
      Clear = 1'b0;
      @(negedge Clock);
      Clear = 1'b1;
      @(negedge Clock);
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL coll_ovf_cleared: got %b want 0", Overflow); end
      fork
         begin
            OutData = words[0];
            Strobe  = 1'b1;
            @(negedge Clock);
            Strobe  = 1'b0;
            @(negedge Clock);
            t0 = cyc;
            for (int k = 1; k <= 4; k++) begin
               OutData = words[k];
               Strobe  = 1'b1;
               @(negedge Clock);
               Strobe  = 1'b0;
               @(negedge Clock);
            end
            while (cyc < t0 + 159) @(negedge Clock);
            checks++;
            if (FifoCount !== 3'd4 || Tx !== 1'b1) begin
               errors++; $display("FAIL coll_before: count %0d tx %b want 4 1", FifoCount, Tx);
            end
            OutData = words[5];
            Strobe  = 1'b1;
            @(negedge Clock);
            Strobe  = 1'b0;
            checks++; if (FifoCount !== 3'd4) begin errors++; $display("FAIL coll_count: got %0d want 4", FifoCount); end
            checks++; if (Overflow !== 1'b0)  begin errors++; $display("FAIL coll_ovf: got %b want 0", Overflow); end
            checks++; if (Tx !== 1'b0)        begin errors++; $display("FAIL coll_next_start: got %b want 0", Tx); end
         end
         begin
            for (int j = 0; j < 24; j++) begin
               recv_byte(b, w, ok);
               checks++;
               if (!ok || b !== words[j/4][8*(j%4) +: 8]) begin
                  errors++; $display("FAIL coll_byte%0d: got %h frame_ok=%0d want %h", j, b, ok, words[j/4][8*(j%4) +: 8]);
               end
            end
         end
      join
      n = 0;
      while (Busy === 1'b1 && n < 50) begin @(negedge Clock); n++; end
      checks++; if (Busy !== 1'b0 || Overflow !== 1'b0) begin
         errors++; $display("FAIL coll_end: busy %b ovf %b want 0 0", Busy, Overflow);
      end
   endtask

   task automatic test_reset_mid_frame;
      int t0, bad;
      @(negedge Clock);
      OutData = 32'h1122_3344;
      Strobe  = 1'b1;
      @(negedge Clock);
      Strobe  = 1'b0;
      @(negedge Clock);
      t0 = cyc;
      OutData = 32'h5566_7788;
      Strobe  = 1'b1;
      @(negedge Clock);
      Strobe  = 1'b0;
      while (cyc < t0 + 57) @(negedge Clock);
      checks++;
      if (Tx !== 1'b0 || FifoCount !== 3'd1) begin
         errors++; $display("FAIL midrst_pre: tx %b count %0d want 0 1", Tx, FifoCount);
      end
      #1 Clear = 1'b0;
      #1;
      checks++; if (Tx !== 1'b1)        begin errors++; $display("FAIL midrst_tx_async: got %b want 1", Tx); end
      checks++; if (FifoCount !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", FifoCount); end
      checks++; if (Busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b want 0", Busy); end
      repeat (3) @(negedge Clock);
      Clear = 1'b1;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge Clock);
         if (Tx !== 1'b1 || Busy !== 1'b0 || FifoCount !== 3'd0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL midrst_idle: %0d active cycles after release want 0", bad); end
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b want 0", Overflow); end
   endtask

   initial begin
      Clear   = 1'b0;
      Strobe  = 1'b0;
      OutData = 32'h0;
      test_reset();
      test_single_word();
      test_long_strobe();
      test_back_to_back();
      test_overflow();
      test_collision();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
